// File: rtl/alu_mem_unit.sv
// alu_mem_unit: execute/memory stage of the 16-bit single-cycle datapath.
//
// Decodes the controller ALU class plus the instruction opcode into a 3-bit
// ALU operation, runs the 16-bit ALU and serves a word-organised data memory
// addressed by the ALU result. Only the memory array holds state.
//
// Ports:
//   clk             system clock, memory updates on rising edge
//   rst             synchronous active-high reset, clears every memory word
//   alu_op[1:0]     controller ALU class (00 R-type, 01 branch, 10 ld/st, 11 rsvd)
//   opcode[3:0]     instruction[15:12]
//   a[15:0]         operand A
//   b[15:0]         operand B
//   mem_write_data  store data
//   mem_w, mem_r    memory write / read enables
//   alu_cnt[2:0]    decoded ALU operation
//   alu_result      ALU result, also the memory byte address
//   iszero          alu_result == 0
//   mem_read_data   combinational read data, 0 when mem_r is low

module alu_mem_unit #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  alu_op,
    input  logic [3:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] mem_write_data,
    input  logic        mem_w,
    input  logic        mem_r,
    output logic [2:0]  alu_cnt,
    output logic [15:0] alu_result,
    output logic        iszero,
    output logic [15:0] mem_read_data
);

    logic [15:0]          mem_q [MEM_WORDS];
    logic [15:0]          mem_d [MEM_WORDS];
    logic [ADDR_BITS-1:0] word_idx;

    always_comb begin
        alu_cnt = 3'b000;
        unique case (alu_op)
            2'b10: alu_cnt = 3'b000;
            2'b01: alu_cnt = 3'b001;
            2'b00: begin
                case (opcode)
                    4'b0010: alu_cnt = 3'b000;
                    4'b0011: alu_cnt = 3'b001;
                    4'b0100: alu_cnt = 3'b010;
                    4'b0101: alu_cnt = 3'b011;
                    4'b0110: alu_cnt = 3'b100;
                    4'b0111: alu_cnt = 3'b101;
                    4'b1000: alu_cnt = 3'b110;
                    4'b1001: alu_cnt = 3'b111;
                    default: alu_cnt = 3'b000;
                endcase
            end
            default: alu_cnt = 3'b000;
        endcase
    end

    always_comb begin
        alu_result = 16'h0000;
        unique case (alu_cnt)
            3'b000: alu_result = a + b;
            3'b001: alu_result = a - b;
            3'b010: alu_result = ~a;
            3'b011: alu_result = a << b[3:0];
            3'b100: alu_result = a >> b[3:0];
            3'b101: alu_result = a & b;
            3'b110: alu_result = a | b;
            3'b111: alu_result = {15'd0, (a < b)};
            default: alu_result = 16'h0000;
        endcase
    end

    assign iszero = (alu_result == 16'h0000);

    // Byte address: bit 0 selects within the word and is dropped; bits above
    // the index are ignored so addresses wrap.
    assign word_idx = alu_result[ADDR_BITS:1];

    // Read is combinational from the current array, so a same-word write
    // is only visible after the edge.
    assign mem_read_data = mem_r ? mem_q[word_idx] : 16'h0000;

    always_comb begin
        mem_d = mem_q;
        if (mem_w) begin
            mem_d[word_idx] = mem_write_data;
        end
    end

    // Reset clears the array and wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: 16'h0000};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_alu_mem_unit.sv
module tb_alu_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alu_op;
    logic [3:0]  opcode;
    logic [15:0] a, b, mem_write_data;
    logic        mem_w, mem_r;
    logic [2:0]  alu_cnt;
    logic [15:0] alu_result;
    logic        iszero;
    logic [15:0] mem_read_data;

    alu_mem_unit #(.MEM_WORDS(256), .ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .opcode(opcode),
        .a(a), .b(b), .mem_write_data(mem_write_data),
        .mem_w(mem_w), .mem_r(mem_r),
        .alu_cnt(alu_cnt), .alu_result(alu_result),
        .iszero(iszero), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  cnt;
        logic [15:0] res;
        logic        z;
        logic [15:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: the DUT presents a new response every cycle that stimulus
    // pushed one; compare mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (alu_cnt !== e.cnt || alu_result !== e.res ||
                iszero !== e.z || mem_read_data !== e.rd) begin
                n_bad++;
                $display("FAIL %s: got cnt=%b res=%h z=%b rd=%h, want cnt=%b res=%h z=%b rd=%h",
                         e.name, alu_cnt, alu_result, iszero, mem_read_data,
                         e.cnt, e.res, e.z, e.rd);
            end
        end
    end

    task automatic vec(input string name, input logic r, input logic [1:0] op,
                       input logic [3:0] opc, input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] wd, input logic mw, input logic mr,
                       input logic [2:0] ecnt, input logic [15:0] eres,
                       input logic ez, input logic [15:0] erd);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; alu_op = op; opcode = opc; a = va; b = vb;
        mem_write_data = wd; mem_w = mw; mem_r = mr;
        x.name = name; x.cnt = ecnt; x.res = eres; x.z = ez; x.rd = erd;
        sb.push_back(x);
    endtask

    initial begin
        rst = 1'b1; alu_op = 2'b00; opcode = 4'h0; a = 16'h0; b = 16'h0;
        mem_write_data = 16'h0; mem_w = 1'b0; mem_r = 1'b0;
        repeat (2) @(posedge clk);

        vec("reset_state", 1, 2'b10, 4'h0, 16'h0010, 16'h0004, 16'h0, 0, 1, 3'd0, 16'h0014, 0, 16'h0000);

        // decode sweep with a=6, b=3
        vec("dec_0010", 0, 2'b00, 4'b0010, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd0, 16'h0009, 0, 16'h0);
        vec("dec_0011", 0, 2'b00, 4'b0011, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd1, 16'h0003, 0, 16'h0);
        vec("dec_0100", 0, 2'b00, 4'b0100, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd2, 16'hFFF9, 0, 16'h0);
        vec("dec_0101", 0, 2'b00, 4'b0101, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd3, 16'h0030, 0, 16'h0);
        vec("dec_0110", 0, 2'b00, 4'b0110, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd4, 16'h0000, 1, 16'h0);
        vec("dec_0111", 0, 2'b00, 4'b0111, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd5, 16'h0002, 0, 16'h0);
        vec("dec_1000", 0, 2'b00, 4'b1000, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd6, 16'h0007, 0, 16'h0);
        vec("dec_1001", 0, 2'b00, 4'b1001, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd7, 16'h0000, 1, 16'h0);
        vec("dec_0000", 0, 2'b00, 4'b0000, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd0, 16'h0009, 0, 16'h0);
        vec("dec_op10", 0, 2'b10, 4'b1001, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd0, 16'h0009, 0, 16'h0);
        vec("dec_op01", 0, 2'b01, 4'b0010, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd1, 16'h0003, 0, 16'h0);
        vec("dec_op11", 0, 2'b11, 4'b0101, 16'h0006, 16'h0003, 16'h0, 0, 0, 3'd0, 16'h0009, 0, 16'h0);

        // arithmetic, logic, shifts
        vec("add_wrap", 0, 2'b00, 4'b0010, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 3'd0, 16'h0000, 1, 16'h0);
        vec("sub_neg",  0, 2'b00, 4'b0011, 16'h0005, 16'h0007, 16'h0, 0, 0, 3'd1, 16'hFFFE, 0, 16'h0);
        vec("slt_lt",   0, 2'b00, 4'b1001, 16'h0003, 16'h8000, 16'h0, 0, 0, 3'd7, 16'h0001, 0, 16'h0);
        vec("slt_ge",   0, 2'b00, 4'b1001, 16'h8000, 16'h0003, 16'h0, 0, 0, 3'd7, 16'h0000, 1, 16'h0);
        vec("not_ffff", 0, 2'b00, 4'b0100, 16'hFFFF, 16'h1234, 16'h0, 0, 0, 3'd2, 16'h0000, 1, 16'h0);
        vec("shl_mask", 0, 2'b00, 4'b0101, 16'h0001, 16'h0013, 16'h0, 0, 0, 3'd3, 16'h0008, 0, 16'h0);
        vec("shr_15",   0, 2'b00, 4'b0110, 16'h8000, 16'h000F, 16'h0, 0, 0, 3'd4, 16'h0001, 0, 16'h0);
        vec("and",      0, 2'b00, 4'b0111, 16'hF0F0, 16'h0FF0, 16'h0, 0, 0, 3'd5, 16'h00F0, 0, 16'h0);
        vec("or",       0, 2'b00, 4'b1000, 16'hF0F0, 16'h0FF0, 16'h0, 0, 0, 3'd6, 16'hFFF0, 0, 16'h0);

        // store / load / aliasing
        vec("st_beef",  0, 2'b10, 4'h0, 16'h0010, 16'h0004, 16'hBEEF, 1, 0, 3'd0, 16'h0014, 0, 16'h0000);
        vec("ld_0014",  0, 2'b10, 4'h0, 16'h0010, 16'h0004, 16'h0000, 0, 1, 3'd0, 16'h0014, 0, 16'hBEEF);
        vec("ld_0015",  0, 2'b10, 4'h0, 16'h0011, 16'h0004, 16'h0000, 0, 1, 3'd0, 16'h0015, 0, 16'hBEEF);
        vec("ld_0214",  0, 2'b10, 4'h0, 16'h0210, 16'h0004, 16'h0000, 0, 1, 3'd0, 16'h0214, 0, 16'hBEEF);
        vec("ld_off",   0, 2'b10, 4'h0, 16'h0010, 16'h0004, 16'h0000, 0, 0, 3'd0, 16'h0014, 0, 16'h0000);

        // same-word read during write
        vec("st_1111",  0, 2'b10, 4'h0, 16'h0020, 16'h0000, 16'h1111, 1, 0, 3'd0, 16'h0020, 0, 16'h0000);
        vec("rdw_pre",  0, 2'b10, 4'h0, 16'h0020, 16'h0000, 16'h2222, 1, 1, 3'd0, 16'h0020, 0, 16'h1111);
        vec("rdw_post", 0, 2'b10, 4'h0, 16'h0020, 16'h0000, 16'h0000, 0, 1, 3'd0, 16'h0020, 0, 16'h2222);

        // reset clears everything and beats a concurrent write
        vec("st_w0",    0, 2'b10, 4'h0, 16'h0000, 16'h0000, 16'hAAAA, 1, 0, 3'd0, 16'h0000, 1, 16'h0000);
        vec("st_w255",  0, 2'b10, 4'h0, 16'h01FE, 16'h0000, 16'h5555, 1, 0, 3'd0, 16'h01FE, 0, 16'h0000);
        vec("ld_w0",    0, 2'b10, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'd0, 16'h0000, 1, 16'hAAAA);
        vec("ld_w255",  0, 2'b10, 4'h0, 16'h01FE, 16'h0000, 16'h0000, 0, 1, 3'd0, 16'h01FE, 0, 16'h5555);
        vec("rst_wr",   1, 2'b10, 4'h0, 16'h0000, 16'h0000, 16'h1234, 1, 1, 3'd0, 16'h0000, 1, 16'hAAAA);
        vec("post_w0",  0, 2'b10, 4'h0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 3'd0, 16'h0000, 1, 16'h0000);
        vec("post_w255",0, 2'b10, 4'h0, 16'h01FE, 16'h0000, 16'h0000, 0, 1, 3'd0, 16'h01FE, 0, 16'h0000);
        vec("post_0014",0, 2'b10, 4'h0, 16'h0010, 16'h0004, 16'h0000, 0, 1, 3'd0, 16'h0014, 0, 16'h0000);
        vec("post_0020",0, 2'b10, 4'h0, 16'h0020, 16'h0000, 16'h0000, 0, 1, 3'd0, 16'h0020, 0, 16'h0000);

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
